// File: rtl/logic_op_pkg.sv
// Shared types for the lane-reduction pipeline: operator and FSM state enums,
// plus the operator mapping used by the lane reducer.
package logic_op_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2,
    OP_NOR = 2'd3
  } op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_e;

  // NOR folds like OR; the inversion happens only when the result is loaded.
  function automatic op_e fold_op(input op_e op);
    op_e res;
    case (op)
      OP_NOR:  res = OP_OR;
      default: res = op;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/logic_reduce_lanes.sv
// Combinational reduction of NUM_IN lanes to one WIDTH-bit word.
// NOR is reported as OR so the caller can keep folding across beats.
module logic_reduce_lanes
  import logic_op_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN*WIDTH-1:0] lanes_i,
  input  op_e                     op_i,
  output logic [WIDTH-1:0]        red_o
);

  // Fold every lane into the running value, starting from the op's identity.
  always_comb begin
    red_o = (fold_op(op_i) == OP_AND) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    for (int k = 0; k < NUM_IN; k++) begin
      case (fold_op(op_i))
        OP_AND:  red_o = red_o & lanes_i[k*WIDTH +: WIDTH];
        OP_XOR:  red_o = red_o ^ lanes_i[k*WIDTH +: WIDTH];
        default: red_o = red_o | lanes_i[k*WIDTH +: WIDTH];
      endcase
    end
  end

endmodule

// File: rtl/logic_reduce_pipe.sv
// Registered lane-reduction unit with valid/ready on both sides and an
// optional frame-accumulate mode that folds several beats into one result.
module logic_reduce_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [1:0]              in_op,
  input  logic                    in_acc,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_valid_q, out_valid_d;

  op_e                in_op_s;
  op_e                lane_op_s;
  logic [WIDTH-1:0]   lane_red_s;
  logic [WIDTH-1:0]   fold_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               accept_s;

  function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input op_e              op);
    logic [WIDTH-1:0] res;
    case (op)
      OP_AND:  res = a & b;
      OP_XOR:  res = a ^ b;
      default: res = a | b;
    endcase
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] finish(input logic [WIDTH-1:0] v,
                                              input op_e              op);
    return (op == OP_NOR) ? ~v : v;
  endfunction

  assign in_op_s   = op_e'(in_op);
  // Mid-frame beats reduce with the op latched on the first beat.
  assign lane_op_s = (state_q == S_ACCUM) ? op_q : in_op_s;
  assign in_ready  = !out_valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign fold_s    = combine(acc_q, lane_red_s, op_q);
  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;

  logic_reduce_lanes #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_lanes (
    .lanes_i (in_data),
    .op_i    (lane_op_s),
    .red_o   (lane_red_s)
  );

  // Next-state for the frame FSM, accumulator and output register.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q && !out_ready;
    if (accept_s) begin
      case (state_q)
        S_IDLE: begin
          if (in_acc && !in_last) begin
            acc_d   = lane_red_s;
            op_d    = in_op_s;
            cnt_d   = CNT_ONE;
            state_d = S_ACCUM;
          end else begin
            out_data_d  = finish(lane_red_s, in_op_s);
            out_count_d = CNT_ONE;
            out_valid_d = 1'b1;
          end
        end
        S_ACCUM: begin
          if (in_last) begin
            out_data_d  = finish(fold_s, op_q);
            out_count_d = cnt_inc_s;
            out_valid_d = 1'b1;
            acc_d       = {WIDTH{1'b0}};
            cnt_d       = {CNT_W{1'b0}};
            state_d     = S_IDLE;
          end else begin
            acc_d = fold_s;
            cnt_d = cnt_inc_s;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_OR;
      acc_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      out_data_q  <= {WIDTH{1'b0}};
      out_count_q <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Self-checking bench for logic_reduce_pipe: directed table, corner sequences
// and random traffic against a beat-list reference model.
module tb_logic_reduce_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [1:0]  in_op;
  logic        in_acc, in_last, in_valid, in_ready;
  logic [7:0]  out_data;
  logic [7:0]  out_count;
  logic        out_valid, out_ready;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: registered result plus the beats of the open frame.
  logic        m_valid;
  logic [7:0]  m_data;
  logic [7:0]  m_count;
  logic [31:0] frame[$];
  logic [1:0]  f_op;
  logic        f_acc;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  op;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs[7];

  logic_reduce_pipe #(.WIDTH(8), .NUM_IN(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_acc    (in_acc),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per bit position, count the ones over every lane of every beat in the frame.
  function automatic logic [7:0] model_reduce();
    logic [7:0] r;
    int total;
    total = frame.size() * 4;
    for (int b = 0; b < 8; b++) begin
      int ones = 0;
      foreach (frame[i])
        for (int l = 0; l < 4; l++) ones += int'(frame[i][l*8 + b]);
      case (f_op)
        2'd0:    r[b] = (ones > 0);
        2'd1:    r[b] = (ones == total);
        2'd2:    r[b] = ((ones % 2) == 1);
        default: r[b] = (ones == 0);
      endcase
    end
    return r;
  endfunction

  task automatic cyc();
    logic acc_now;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    acc_now = in_valid && (!m_valid || out_ready) && !reset;
    if (reset) begin
      m_valid = 1'b0;
      m_data  = 8'd0;
      m_count = 8'd0;
      frame.delete();
    end else begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (acc_now) begin
        if (frame.size() == 0) begin
          f_op  = in_op;
          f_acc = in_acc;
        end
        frame.push_back(in_data);
        if (!f_acc || in_last) begin
          m_data  = model_reduce();
          m_count = (frame.size() > 255) ? 8'd255 : 8'(frame.size());
          m_valid = 1'b1;
          frame.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_count", 32'(out_count), 32'(m_count));
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] op, input logic acc, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_acc   = acc;
    in_last  = last;
  endtask

  task automatic idle_cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
  endtask

  initial begin
    vecs[0] = '{32'h80040201, 2'd0, 8'h87};
    vecs[1] = '{32'hF33CF0FF, 2'd1, 8'h30};
    vecs[2] = '{32'h55AAF00F, 2'd2, 8'h00};
    vecs[3] = '{32'h88442211, 2'd3, 8'h00};
    vecs[4] = '{32'hFFFFFFFF, 2'd1, 8'hFF};
    vecs[5] = '{32'h00010101, 2'd2, 8'h01};
    vecs[6] = '{32'h00000000, 2'd3, 8'hFF};

    m_valid = 1'b0; m_data = 8'd0; m_count = 8'd0; f_op = 2'd0; f_acc = 1'b0;
    reset = 1'b1; in_data = 32'd0; in_op = 2'd0; in_acc = 1'b0; in_last = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;

    @(posedge clk); #1;
    cyc(); cyc();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back single beats at full throughput.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      beat(vecs[i].data, vecs[i].op, 1'b0, 1'b0);
      cyc();
      chk("vec_data", 32'(out_data), 32'(vecs[i].exp));
      chk("vec_count", 32'(out_count), 32'd1);
      chk("vec_in_ready", 32'(in_ready), 32'd1);
    end
    idle_cycle();

    // NOR frame; op change on the closing beat must be ignored.
    beat(32'h00000001, 2'd3, 1'b1, 1'b0);
    cyc();
    chk("nor_mid_valid", 32'(out_valid), 32'd0);
    beat(32'h00001000, 2'd1, 1'b0, 1'b1);
    cyc();
    chk("nor_data", 32'(out_data), 32'hEE);
    chk("nor_count", 32'(out_count), 32'd2);
    idle_cycle();

    // Backpressure hold, then accept on the cycle out_ready rises.
    out_ready = 1'b0;
    beat(32'h80040201, 2'd0, 1'b0, 1'b0);
    cyc();
    beat(32'h00000003, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_data", 32'(out_data), 32'h87);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("release_data", 32'(out_data), 32'h03);
    chk("release_valid", 32'(out_valid), 32'd1);
    idle_cycle();

    // Reset in the middle of a frame drops the partial result.
    beat(32'h12345678, 2'd0, 1'b1, 1'b0);
    cyc();
    beat(32'h9ABCDEF0, 2'd0, 1'b1, 1'b0);
    cyc();
    in_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    beat(32'h88442211, 2'd0, 1'b0, 1'b0);
    cyc();
    chk("midrst_data", 32'(out_data), 32'hFF);
    chk("midrst_count", 32'(out_count), 32'd1);
    idle_cycle();

    // 300-beat frame saturates the beat counter.
    for (int i = 0; i < 300; i++) begin
      beat((i == 150) ? 32'h00000001 : 32'h00000000, 2'd0, 1'b1, (i == 299));
      cyc();
    end
    chk("sat_data", 32'(out_data), 32'h01);
    chk("sat_count", 32'(out_count), 32'hFF);
    chk("sat_valid", 32'(out_valid), 32'd1);
    idle_cycle();

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_op     = 2'($urandom_range(0, 3));
      in_acc    = 1'($urandom_range(0, 1));
      in_last   = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 1'b0;
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
